aes_inv_round_seq: RTL and testbench



---
 rtl/aes_inv_pkg.sv | 75 +++++++
 rtl/aes_inv_round_seq_inv_s.sv | 41 ++++
 rtl/aes_inv_round_seq.sv | 143 ++++++++++++++
 tb/tb_aes_inv_round_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_pkg
// Description : Shared types and GF(2^8) helpers for the iterative AES
//               inverse round engine: FSM state encoding, reduction and
//               InvMixColumns constants, xtime, gf_mul, inv_mix_col and
//               inv_shift_rows. Byte 0 of a 128-bit block is [127:120];
//               byte i = 4*column + row (column-major).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_inv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] c_GF_RED  = 8'h1b;
    localparam logic [7:0] c_MUL_09  = 8'h09;
    localparam logic [7:0] c_MUL_0B  = 8'h0b;
    localparam logic [7:0] c_MUL_0D  = 8'h0d;
    localparam logic [7:0] c_MUL_0E  = 8'h0e;
    localparam logic [2:0] c_CNT_END = 3'd4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? c_GF_RED : 8'h00);
    endfunction

    // Only the four InvMixColumns coefficients are supported.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] coef);
        logic [7:0] x2, x4, x8, res;
        x2  = xtime(b);
        x4  = xtime(x2);
        x8  = xtime(x4);
        res = 8'h00;
        case (coef)
            c_MUL_09: res = x8 ^ b;
            c_MUL_0B: res = x8 ^ x2 ^ b;
            c_MUL_0D: res = x8 ^ x4 ^ b;
            c_MUL_0E: res = x8 ^ x4 ^ x2;
            default:  res = 8'h00;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        o0 = gf_mul(a0, c_MUL_0E) ^ gf_mul(a1, c_MUL_0B) ^ gf_mul(a2, c_MUL_0D) ^ gf_mul(a3, c_MUL_09);
        o1 = gf_mul(a0, c_MUL_09) ^ gf_mul(a1, c_MUL_0E) ^ gf_mul(a2, c_MUL_0B) ^ gf_mul(a3, c_MUL_0D);
        o2 = gf_mul(a0, c_MUL_0D) ^ gf_mul(a1, c_MUL_09) ^ gf_mul(a2, c_MUL_0E) ^ gf_mul(a3, c_MUL_0B);
        o3 = gf_mul(a0, c_MUL_0B) ^ gf_mul(a1, c_MUL_0D) ^ gf_mul(a2, c_MUL_09) ^ gf_mul(a3, c_MUL_0E);
        return {o0, o1, o2, o3};
    endfunction

    // Row r of column c takes the byte from row r, column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round_seq_inv_s.sv
`default_nettype none
// ============================================================================
// Module      : inv_s
// Description : AES inverse S-box, 256-entry table with a registered output
//               (1-cycle latency, no reset).
// Ports       : clk - clock
//               in  - byte to substitute
//               out - InvSubBytes(in), valid one cycle after in
// Revision    : 1.0 - initial release
// ============================================================================
module inv_s (
    input  logic       clk,
    input  logic [7:0] in,
    output logic [7:0] out
);

    localparam logic [7:0] c_INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    always_ff @(posedge clk) begin
        out <= c_INV_SBOX[in];
    end

endmodule
`default_nettype wire

// File: rtl/aes_inv_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_round_seq
// Description : Iterative AES inverse round. One accepted word is processed
//               as InvShiftRows -> InvSubBytes (4 shared registered S-boxes,
//               one column per cycle) -> AddRoundKey -> InvMixColumns
//               (skipped when last). Result is held until consumed.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready, in_state, in_key, in_last  - request
//               out_valid/out_ready, out_state                - result
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_round_seq
    import aes_inv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    state_t       r_st;
    state_t       w_st_nxt;
    logic [2:0]   r_cnt;
    logic [127:0] r_din;
    logic [127:0] r_key;
    logic         r_last;
    logic [127:0] r_sub;
    logic [127:0] r_out;

    logic [127:0] w_isr;
    logic [31:0]  w_col;
    logic [31:0]  w_sb_col;
    logic [127:0] w_ark;
    logic [127:0] w_mixed;

    assign in_ready  = (r_st == ST_IDLE);
    assign out_valid = (r_st == ST_DONE);
    assign out_state = r_out;

    // Column selection follows the counter; at counter 4 column 0 is
    // presented again but its S-box result is never written.
    assign w_isr = inv_shift_rows(r_din);

    always_comb begin
        w_col = w_isr[127:96];
        case (r_cnt[1:0])
            2'd0: w_col = w_isr[127:96];
            2'd1: w_col = w_isr[95:64];
            2'd2: w_col = w_isr[63:32];
            2'd3: w_col = w_isr[31:0];
            default: w_col = w_isr[127:96];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            inv_s u_inv_s (
                .clk (clk),
                .in  (w_col[31 - 8*gi -: 8]),
                .out (w_sb_col[31 - 8*gi -: 8])
            );
        end
    endgenerate

    assign w_ark = r_sub ^ r_key;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign w_mixed[127 - 32*gi -: 32] = inv_mix_col(w_ark[127 - 32*gi -: 32]);
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            ST_IDLE: if (in_valid) w_st_nxt = ST_SUB;
            ST_SUB:  if (r_cnt == c_CNT_END) w_st_nxt = ST_MIX;
            ST_MIX:  w_st_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_st_nxt = ST_IDLE;
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 3'd0;
            r_din  <= '0;
            r_key  <= '0;
            r_last <= 1'b0;
            r_sub  <= '0;
            r_out  <= '0;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_din  <= in_state;
                        r_key  <= in_key;
                        r_last <= in_last;
                        r_cnt  <= 3'd0;
                    end
                end
                ST_SUB: begin
                    if (r_cnt != c_CNT_END) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                    // S-box output lags the presented column by one cycle.
                    case (r_cnt)
                        3'd1: r_sub[127:96] <= w_sb_col;
                        3'd2: r_sub[95:64]  <= w_sb_col;
                        3'd3: r_sub[63:32]  <= w_sb_col;
                        3'd4: r_sub[31:0]   <= w_sb_col;
                        default: ;
                    endcase
                end
                ST_MIX: begin
                    r_out <= r_last ? w_ark : w_mixed;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_round_seq
// Description : Self-checking bench for aes_inv_round_seq. A behavioural
//               AES model computes each expected round result when a request
//               is accepted; results are queued and compared on output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_round_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] rk[11];

    localparam logic [127:0] c_PLAIN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CIPH  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

    aes_inv_round_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] m_ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = m_gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] s;
        s = m_ginv(x);
        return s ^ m_rotl(s, 1) ^ m_rotl(s, 2) ^ m_rotl(s, 3) ^ m_rotl(s, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] m_inv_sbox(input logic [7:0] x);
        return m_ginv(m_rotl(x, 1) ^ m_rotl(x, 3) ^ m_rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k, input logic l);
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c + r] = m_inv_sbox(a[4*((c - r + 4) % 4) + r]) ^ k[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++) begin
            if (l) begin
                for (int r = 0; r < 4; r++) a[4*c + r] = b[4*c + r];
            end else begin
                a[4*c+0] = m_gmul(b[4*c], 8'h0e) ^ m_gmul(b[4*c+1], 8'h0b) ^ m_gmul(b[4*c+2], 8'h0d) ^ m_gmul(b[4*c+3], 8'h09);
                a[4*c+1] = m_gmul(b[4*c], 8'h09) ^ m_gmul(b[4*c+1], 8'h0e) ^ m_gmul(b[4*c+2], 8'h0b) ^ m_gmul(b[4*c+3], 8'h0d);
                a[4*c+2] = m_gmul(b[4*c], 8'h0d) ^ m_gmul(b[4*c+1], 8'h09) ^ m_gmul(b[4*c+2], 8'h0e) ^ m_gmul(b[4*c+3], 8'h0b);
                a[4*c+3] = m_gmul(b[4*c], 8'h0b) ^ m_gmul(b[4*c+1], 8'h0d) ^ m_gmul(b[4*c+2], 8'h09) ^ m_gmul(b[4*c+3], 8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = a[i];
        return res;
    endfunction

    task automatic build_keys();
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = c_KEY[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = m_gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l, output int ok);
        logic acc;
        in_valid = 1'b1; in_state = s; in_key = k; in_last = l;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (ok != 0) exp_q.push_back(m_round(s, k, l));
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [127:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_state = '0; in_key = '0; in_last = 1'b0;
        repeat (3) tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state: got %h want 0", out_state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_c1_last();
        int ok, cyc;
        logic [127:0] e;
        send(128'h6353e08c0960e104cd70b751bacad0e7, c_KEY, 1'b1, ok);
        wait_out(cyc);
        total++;
        if (ok == 0 || cyc != 6) begin bad++; $display("FAIL c1_latency: got %0d edges (accept=%0d) want 6", cyc, ok); end
        e = pop_exp();
        total++;
        if (out_state !== e) begin bad++; $display("FAIL c1_model: got %h want %h", out_state, e); end
        total++;
        if (out_state !== c_PLAIN) begin bad++; $display("FAIL c1_vector: got %h want %h", out_state, c_PLAIN); end
        consume();
    endtask

    task automatic test_zero();
        int ok, cyc;
        logic [127:0] e, k, c;
        for (int i = 0; i < 4; i++) begin
            k = (i >= 2) ? {16{8'h01}} : 128'h0;
            c = (i >= 2) ? {16{8'h53}} : {16{8'h52}};
            send(128'h0, k, i[0], ok);
            wait_out(cyc);
            e = pop_exp();
            total++;
            if (ok == 0 || out_valid !== 1'b1 || out_state !== e)
                begin bad++; $display("FAIL zero_model[%0d]: got %h want %h", i, out_state, e); end
            total++;
            if (out_state !== c) begin bad++; $display("FAIL zero_const[%0d]: got %h want %h", i, out_state, c); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int ok, cyc;
        logic [127:0] e, s, k;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(s, k, 1'b0, ok);
        wait_out(cyc);
        e = pop_exp();
        total++;
        if (ok == 0 || out_valid !== 1'b1 || out_state !== e)
            begin bad++; $display("FAIL bp_result: got %h want %h", out_state, e); end
        for (int n = 0; n < 20; n++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== e)
                begin bad++; $display("FAIL bp_hold[%0d]: got v=%b r=%b %h want v=1 r=0 %h", n, out_valid, in_ready, out_state, e); end
        end
        consume();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL bp_release: got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_busy();
        int ok, cyc;
        logic [127:0] e, s, k;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(s, k, 1'b0, ok);
        tick();
        in_valid = 1'b1; in_state = ~s; in_key = ~k; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(cyc);
        e = pop_exp();
        total++;
        if (ok == 0 || out_valid !== 1'b1 || out_state !== e)
            begin bad++; $display("FAIL busy_result: got %h want %h", out_state, e); end
        consume();
        repeat (8) tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL busy_no_extra: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int ok, cyc;
        logic [127:0] e, s, k;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(s, k, 1'b0, ok);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0)
            begin bad++; $display("FAIL rstmid_state: got r=%b v=%b %h want r=1 v=0 0", in_ready, out_valid, out_state); end
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, k, 1'b1, ok);
        wait_out(cyc);
        e = pop_exp();
        total++;
        if (ok == 0 || cyc != 6 || out_state !== e)
            begin bad++; $display("FAIL rstmid_after: got %h (lat %0d) want %h (lat 6)", out_state, cyc, e); end
        consume();
    endtask

    task automatic test_back_to_back();
        int ok, cyc;
        logic [127:0] st, e;
        logic         l;
        build_keys();
        st = c_CIPH ^ rk[10];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            l = (rnd == 10);
            send(st, rk[10 - rnd], l, ok);
            st = m_round(st, rk[10 - rnd], l);
            wait_out(cyc);
            e = pop_exp();
            total++;
            if (ok == 0 || out_valid !== 1'b1 || out_state !== e)
                begin bad++; $display("FAIL b2b_round[%0d]: got %h want %h", rnd, out_state, e); end
            if (rnd == 10) begin
                total++;
                if (out_state !== c_PLAIN)
                    begin bad++; $display("FAIL b2b_plain: got %h want %h", out_state, c_PLAIN); end
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_c1_last();
        test_zero();
        test_backpressure();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
